// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC capture-and-hold latch and its
// field banks.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEAD    = 2'd1,
    CAPTURE = 2'd2,
    PEND    = 2'd3
  } state_t;

  // Field order as delivered by the RTC read sequencer.
  localparam int F_SEG     = 0;
  localparam int F_MIN     = 1;
  localparam int F_HORA    = 2;
  localparam int F_FECHA   = 3;
  localparam int F_MES     = 4;
  localparam int F_ANO     = 5;
  localparam int F_DIA     = 6;
  localparam int F_SEMANA  = 7;
  localparam int F_CR_SEG  = 8;
  localparam int F_CR_MIN  = 9;
  localparam int F_CR_HORA = 10;

  localparam int NUM_FIELDS_DEFAULT = 11;

  function automatic logic nibble_bad(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/rtc_field_bank.sv
// NUM_FIELDS x DATA_W register array with a per-field write port, a bulk
// load of the whole set and a synchronous clear.
module rtc_field_bank #(
  parameter int NUM_FIELDS = 11,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 4
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         load_all,
  input  logic [NUM_FIELDS*DATA_W-1:0] load_data,
  output logic [NUM_FIELDS*DATA_W-1:0] data
);

  // Clear wins over a bulk load, which wins over a single-field write.
  always_ff @(posedge clk) begin
    if (clear) begin
      data <= '0;
    end else if (load_all) begin
      data <= load_data;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        if (wr_idx == IDX_W'(k)) data[k*DATA_W +: DATA_W] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/rtc_frame_latch.sv
// Captures a burst of RTC fields into a shadow bank and commits the complete
// set to the display bank on a frame boundary, so a frame never mixes sets.
module rtc_frame_latch
  import rtc_pkg::*;
#(
  parameter int NUM_FIELDS  = NUM_FIELDS_DEFAULT,
  parameter int DATA_W      = 8,
  parameter int LEAD_CYCLES = 10,
  parameter int BCD_CHECK   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inicioSecuencia,
  input  logic [DATA_W-1:0]            datoRTC,
  input  logic                         frame_tick,
  output logic [NUM_FIELDS*DATA_W-1:0] display_bus,
  output logic [NUM_FIELDS-1:0]        bcd_err,
  output logic                         valid,
  output logic                         busy,
  output logic                         abort_err,
  output logic                         overrun,
  output state_t                       fsm_state
);

  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_FIELDS - 1);
  localparam logic [7:0]       LEAD_LAST = 8'(LEAD_CYCLES - 1);

  state_t                       state, state_n;
  logic                         start_q, start_rise;
  logic [7:0]                   lead_cnt, lead_n;
  logic [IDX_W-1:0]             idx, idx_n, wr_idx;
  logic                         wr_en, commit, abort_n, overrun_n;
  logic                         launch, first_field;
  logic [NUM_FIELDS*DATA_W-1:0] shadow_bus;
  logic [NUM_FIELDS-1:0]        bcd_mask;

  assign start_rise = inicioSecuencia & ~start_q;

  // The edge that enters CAPTURE also samples field 0, so field k lands at
  // E0 + LEAD_CYCLES + k and PEND is entered on the last sample.
  always_comb begin
    state_n     = state;
    lead_n      = lead_cnt;
    idx_n       = idx;
    wr_en       = 1'b0;
    wr_idx      = idx;
    commit      = 1'b0;
    abort_n     = 1'b0;
    overrun_n   = 1'b0;
    launch      = 1'b0;
    first_field = 1'b0;
    case (state)
      IDLE: launch = start_rise;
      LEAD: begin
        if (!inicioSecuencia) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (lead_cnt == LEAD_LAST) begin
          first_field = 1'b1;
        end else begin
          lead_n = lead_cnt + 8'd1;
        end
      end
      CAPTURE: begin
        if (!inicioSecuencia) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else begin
          wr_en = 1'b1;
          if (idx == IDX_LAST) state_n = PEND;
          else idx_n = idx + IDX_W'(1);
        end
      end
      PEND: begin
        if (frame_tick) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
        if (start_rise) begin
          launch    = 1'b1;
          overrun_n = ~frame_tick;
        end
      end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      if (LEAD_CYCLES == 0) begin
        first_field = 1'b1;
      end else begin
        state_n = LEAD;
        lead_n  = '0;
      end
    end
    if (first_field) begin
      wr_en  = 1'b1;
      wr_idx = '0;
      if (NUM_FIELDS == 1) begin
        state_n = PEND;
      end else begin
        state_n = CAPTURE;
        idx_n   = IDX_W'(1);
      end
    end
  end

  // Nibbles beyond the last whole nibble of a field are not checked.
  always_comb begin
    bcd_mask = '0;
    if (BCD_CHECK != 0) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        for (int j = 0; j < DATA_W / 4; j++) begin
          if (nibble_bad(shadow_bus[k*DATA_W + j*4 +: 4])) bcd_mask[k] = 1'b1;
        end
      end
    end
  end

  // valid rises on the first commit and stays high until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      lead_cnt  <= '0;
      idx       <= '0;
      valid     <= 1'b0;
      bcd_err   <= '0;
      abort_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      start_q   <= inicioSecuencia;
      lead_cnt  <= lead_n;
      idx       <= idx_n;
      abort_err <= abort_n;
      overrun   <= overrun_n;
      if (commit) begin
        valid   <= 1'b1;
        bcd_err <= bcd_mask;
      end
    end
  end

  rtc_field_bank #(
    .NUM_FIELDS(NUM_FIELDS),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_shadow (
    .clk      (clk),
    .clear    (reset),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (datoRTC),
    .load_all (1'b0),
    .load_data('0),
    .data     (shadow_bus)
  );

  rtc_field_bank #(
    .NUM_FIELDS(NUM_FIELDS),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_display (
    .clk      (clk),
    .clear    (reset),
    .wr_en    (1'b0),
    .wr_idx   ('0),
    .wr_data  ('0),
    .load_all (commit),
    .load_data(shadow_bus),
    .data     (display_bus)
  );

  assign busy      = (state == LEAD) || (state == CAPTURE);
  assign fsm_state = state;

endmodule

// File: tb/tb_rtc_frame_latch.sv
// Self-checking bench for rtc_frame_latch: default instance, a BCD_CHECK=0
// twin on the same stimulus, and a 3x16 zero-lead instance.
module tb_rtc_frame_latch;
  import rtc_pkg::*;

  localparam int N  = 11;
  localparam int W  = 8;
  localparam int L  = 10;
  localparam int DW = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, frame_tick;
  logic [W-1:0]  dato;
  logic [DW-1:0] display_bus, display_nb;
  logic [N-1:0]  bcd_err, bcd_nb;
  logic          valid, busy, abort_err, overrun;
  logic          valid_nb, busy_nb, abort_nb, overrun_nb;
  state_t        fsm_state, state_nb;

  logic          s_reset, s_start, s_frame;
  logic [15:0]   s_dato;
  logic [47:0]   s_display;
  logic [2:0]    s_bcd;
  logic          s_valid, s_busy, s_abort, s_overrun;
  state_t        s_state;

  rtc_frame_latch dut (
    .clk(clk), .reset(reset), .inicioSecuencia(start), .datoRTC(dato),
    .frame_tick(frame_tick), .display_bus(display_bus), .bcd_err(bcd_err),
    .valid(valid), .busy(busy), .abort_err(abort_err), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  rtc_frame_latch #(.BCD_CHECK(0)) dut_nb (
    .clk(clk), .reset(reset), .inicioSecuencia(start), .datoRTC(dato),
    .frame_tick(frame_tick), .display_bus(display_nb), .bcd_err(bcd_nb),
    .valid(valid_nb), .busy(busy_nb), .abort_err(abort_nb), .overrun(overrun_nb),
    .fsm_state(state_nb)
  );

  rtc_frame_latch #(.NUM_FIELDS(3), .DATA_W(16), .LEAD_CYCLES(0)) dut_small (
    .clk(clk), .reset(s_reset), .inicioSecuencia(s_start), .datoRTC(s_dato),
    .frame_tick(s_frame), .display_bus(s_display), .bcd_err(s_bcd),
    .valid(s_valid), .busy(s_busy), .abort_err(s_abort), .overrun(s_overrun),
    .fsm_state(s_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending sets waiting for a frame and the committed view.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_disp;
  logic [N-1:0]  exp_mask;
  logic          exp_valid;
  logic          exp_ov;
  logic [W-1:0]  fields[N];
  logic          seen_ov, seen_ov_next, seen_busy, seen_abort;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack_fields();
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = fields[k];
    return r;
  endfunction

  function automatic logic [N-1:0] bcd_model(input logic [DW-1:0] d);
    logic [N-1:0] m;
    int b;
    for (int k = 0; k < N; k++) begin
      b = int'(d[k*W +: W]);
      m[k] = ((b % 16) > 9) || ((b / 16) > 9);
    end
    return m;
  endfunction

  task automatic commit_model();
    exp_disp  = exp_q.pop_front();
    exp_mask  = bcd_model(exp_disp);
    exp_valid = 1'b1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_disp  = '0;
    exp_mask  = '0;
    exp_valid = 1'b0;
  endtask

  task automatic rand_fields();
    for (int k = 0; k < N; k++) fields[k] = W'($urandom);
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    if (exp_q.size() > 0) commit_model();
  endtask

  // Drives one burst of fields[]; abort_at/frame_at select the field sample
  // at which start drops or frame_tick is pulsed (-1 for none).
  task automatic run_burst(input int abort_at, input int frame_at, input logic ftk0);
    seen_abort = 1'b0;
    seen_ov = 1'b0;
    seen_ov_next = 1'b0;
    exp_ov = 1'b0;
    if (start) begin
      start = 1'b0;
      tick();
    end
    start = 1'b1;
    frame_tick = ftk0;
    dato = W'($urandom);
    tick();
    seen_ov = overrun;
    seen_busy = busy;
    frame_tick = 1'b0;
    if (exp_q.size() > 0) begin
      if (ftk0) begin
        commit_model();
      end else begin
        void'(exp_q.pop_front());
        exp_ov = 1'b1;
      end
    end
    for (int i = 0; i < L - 1; i++) begin
      dato = W'($urandom);
      tick();
      if (i == 0) seen_ov_next = overrun;
    end
    for (int k = 0; k < N; k++) begin
      dato = fields[k];
      frame_tick = (k == frame_at) ? 1'b1 : 1'b0;
      if (k == abort_at) start = 1'b0;
      tick();
      frame_tick = 1'b0;
      if (k == abort_at) begin
        seen_abort = abort_err;
        return;
      end
    end
    exp_q.push_back(pack_fields());
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; dato = '0;
    tick(); tick();
    model_reset();
    n_checks++; if (display_bus !== '0) $display("FAIL reset_display: got %h want 0", display_bus); else n_pass++;
    n_checks++; if (bcd_err !== '0) $display("FAIL reset_bcd: got %h want 0", bcd_err); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({abort_err, overrun} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {abort_err, overrun}); else n_pass++;
    n_checks++; if (fsm_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", fsm_state); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    fields = '{8'h18, 8'h01, 8'h01, 8'h23, 8'h12, 8'h17, 8'h05, 8'h01, 8'h27, 8'h08, 8'h09};
    run_burst(-1, -1, 1'b0);
    n_checks++; if (seen_busy !== 1'b1) $display("FAIL nominal_busy_lead: got %b want 1", seen_busy); else n_pass++;
    n_checks++; if (fsm_state !== PEND) $display("FAIL nominal_pend: got %0d want PEND", fsm_state); else n_pass++;
    n_checks++; if (display_bus !== '0) $display("FAIL nominal_no_early_commit: got %h want 0", display_bus); else n_pass++;
    repeat ($urandom_range(0, 4)) tick();
    pulse_frame();
    n_checks++; if (display_bus !== 88'h09_08_27_01_05_17_12_23_01_01_18)
      $display("FAIL nominal_display: got %h want 0908270105171223010118", display_bus); else n_pass++;
    n_checks++; if (display_bus !== exp_disp) $display("FAIL nominal_model: got %h want %h", display_bus, exp_disp); else n_pass++;
    n_checks++; if (valid !== 1'b1) $display("FAIL nominal_valid: got %b want 1", valid); else n_pass++;
    n_checks++; if (bcd_err !== '0) $display("FAIL nominal_bcd: got %h want 0", bcd_err); else n_pass++;
    n_checks++; if (fsm_state !== IDLE) $display("FAIL nominal_idle: got %0d want IDLE", fsm_state); else n_pass++;
  endtask

  task automatic test_tear_free();
    rand_fields();
    run_burst(-1, 5, 1'b0);
    n_checks++; if (display_bus !== exp_disp) $display("FAIL tear_mid_capture: got %h want %h", display_bus, exp_disp); else n_pass++;
    pulse_frame();
    n_checks++; if (display_bus !== exp_disp) $display("FAIL tear_commit1: got %h want %h", display_bus, exp_disp); else n_pass++;
    rand_fields();
    run_burst(-1, N - 1, 1'b0);
    n_checks++; if (display_bus !== exp_disp) $display("FAIL tear_last_sample: got %h want %h", display_bus, exp_disp); else n_pass++;
    n_checks++; if (fsm_state !== PEND) $display("FAIL tear_still_pend: got %0d want PEND", fsm_state); else n_pass++;
    pulse_frame();
    n_checks++; if (display_bus !== exp_disp) $display("FAIL tear_commit2: got %h want %h", display_bus, exp_disp); else n_pass++;
  endtask

  task automatic test_abort();
    rand_fields();
    run_burst(4, -1, 1'b0);
    n_checks++; if (seen_abort !== 1'b1) $display("FAIL abort_pulse: got %b want 1", seen_abort); else n_pass++;
    n_checks++; if (fsm_state !== IDLE) $display("FAIL abort_idle: got %0d want IDLE", fsm_state); else n_pass++;
    n_checks++; if (display_bus !== exp_disp) $display("FAIL abort_display_kept: got %h want %h", display_bus, exp_disp); else n_pass++;
    tick();
    n_checks++; if (abort_err !== 1'b0) $display("FAIL abort_one_cycle: got %b want 0", abort_err); else n_pass++;
    pulse_frame();
    n_checks++; if (display_bus !== exp_disp) $display("FAIL abort_no_commit: got %h want %h", display_bus, exp_disp); else n_pass++;
    rand_fields();
    run_burst(-1, -1, 1'b0);
    pulse_frame();
    n_checks++; if (display_bus !== exp_disp) $display("FAIL abort_recover: got %h want %h", display_bus, exp_disp); else n_pass++;
  endtask

  task automatic test_overrun();
    rand_fields();
    run_burst(-1, -1, 1'b0);
    rand_fields();
    run_burst(-1, -1, 1'b0);
    n_checks++; if (seen_ov !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", seen_ov); else n_pass++;
    n_checks++; if (seen_ov_next !== 1'b0) $display("FAIL overrun_one_cycle: got %b want 0", seen_ov_next); else n_pass++;
    n_checks++; if (seen_busy !== 1'b1) $display("FAIL overrun_restart: got %b want 1", seen_busy); else n_pass++;
    pulse_frame();
    n_checks++; if (display_bus !== exp_disp) $display("FAIL overrun_second_set: got %h want %h", display_bus, exp_disp); else n_pass++;
    rand_fields();
    run_burst(-1, -1, 1'b0);
    rand_fields();
    run_burst(-1, -1, 1'b1);
    n_checks++; if (seen_ov !== 1'b0) $display("FAIL simul_no_overrun: got %b want 0", seen_ov); else n_pass++;
    n_checks++; if (display_bus !== exp_disp) $display("FAIL simul_commit: got %h want %h", display_bus, exp_disp); else n_pass++;
    pulse_frame();
    n_checks++; if (display_bus !== exp_disp) $display("FAIL simul_next: got %h want %h", display_bus, exp_disp); else n_pass++;
  endtask

  task automatic test_bcd();
    for (int k = 0; k < N; k++) fields[k] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    fields[3] = 8'h3A;
    fields[5] = 8'hF0;
    run_burst(-1, -1, 1'b0);
    pulse_frame();
    n_checks++; if (bcd_err !== 11'h028) $display("FAIL bcd_mask: got %h want 028", bcd_err); else n_pass++;
    n_checks++; if (bcd_nb !== '0) $display("FAIL bcd_disabled: got %h want 0", bcd_nb); else n_pass++;
    n_checks++; if (display_nb !== exp_disp) $display("FAIL bcd_disabled_display: got %h want %h", display_nb, exp_disp); else n_pass++;
    rand_fields();
    run_burst(-1, -1, 1'b0);
    pulse_frame();
    n_checks++; if (bcd_err !== exp_mask) $display("FAIL bcd_random: got %h want %h", bcd_err, exp_mask); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int ab, fa;
      logic f0;
      rand_fields();
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      fa = int'($urandom_range(0, N + 3));
      if (fa >= N) fa = -1;
      f0 = 1'($urandom_range(0, 1));
      run_burst(ab, fa, f0);
      n_checks++; if (seen_ov !== exp_ov) $display("FAIL rand_overrun it%0d: got %b want %b", it, seen_ov, exp_ov); else n_pass++;
      if (ab >= 0) begin
        n_checks++; if (seen_abort !== 1'b1) $display("FAIL rand_abort it%0d: got %b want 1", it, seen_abort); else n_pass++;
      end
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 2) != 0) pulse_frame();
      n_checks++; if (display_bus !== exp_disp) $display("FAIL rand_display it%0d: got %h want %h", it, display_bus, exp_disp); else n_pass++;
      n_checks++; if (bcd_err !== exp_mask) $display("FAIL rand_bcd it%0d: got %h want %h", it, bcd_err, exp_mask); else n_pass++;
      n_checks++; if (valid !== exp_valid) $display("FAIL rand_valid it%0d: got %b want %b", it, valid, exp_valid); else n_pass++;
    end
  endtask

  task automatic test_param_sweep();
    s_reset = 1'b1; s_start = 1'b0; s_frame = 1'b0; s_dato = '0;
    tick();
    s_reset = 1'b0;
    tick();
    s_start = 1'b1; s_dato = 16'h0001;
    tick();
    n_checks++; if (s_state !== CAPTURE) $display("FAIL sweep_capture_at_e0: got %0d want CAPTURE", s_state); else n_pass++;
    s_dato = 16'h0002; tick();
    s_dato = 16'h0003; tick();
    n_checks++; if (s_state !== PEND) $display("FAIL sweep_pend: got %0d want PEND", s_state); else n_pass++;
    s_start = 1'b0; s_frame = 1'b1;
    tick();
    s_frame = 1'b0;
    n_checks++; if (s_display !== 48'h0003_0002_0001) $display("FAIL sweep_display: got %h want 000300020001", s_display); else n_pass++;
    n_checks++; if (s_valid !== 1'b1) $display("FAIL sweep_valid: got %b want 1", s_valid); else n_pass++;
    s_start = 1'b1; s_dato = 16'($urandom);
    tick();
    s_dato = 16'($urandom);
    s_reset = 1'b1; s_start = 1'b0;
    tick();
    s_reset = 1'b0;
    n_checks++; if (s_valid !== 1'b0) $display("FAIL sweep_reset_valid: got %b want 0", s_valid); else n_pass++;
    n_checks++; if (s_display !== '0) $display("FAIL sweep_reset_display: got %h want 0", s_display); else n_pass++;
    n_checks++; if (s_busy !== 1'b0) $display("FAIL sweep_reset_busy: got %b want 0", s_busy); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; dato = '0;
    s_reset = 1'b1; s_start = 1'b0; s_frame = 1'b0; s_dato = '0;
    test_reset();
    test_nominal();
    test_tear_free();
    test_abort();
    test_overrun();
    test_bcd();
    test_random();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
